// File: rtl/act_lut_controller.sv
// Sequencer for the ActivationFunction datapath: LUT coefficient loading, one-at-a-time requests, result FIFO.
// Optional performance counters are built when ACT_CTRL_PERF_EN is defined.
module act_lut_controller #(
  parameter int Q_SIZE        = 16,
  parameter int ACT_MASK_SIZE = 4,
  parameter int ACT_LUT_DEPTH = 5,
  parameter int ACT_LUT_SIZE  = 32,
  parameter int ACT_LATENCY   = 1,
  parameter int RES_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic [ACT_MASK_SIZE-1:0] load_mask,
  input  logic                     load_valid,
  input  logic [ACT_LUT_SIZE-1:0]  load_data,
  output logic                     load_ready,
  output logic                     load_done,
  input  logic                     req_valid,
  input  logic [Q_SIZE-1:0]        req_x,
  input  logic [ACT_MASK_SIZE-1:0] req_mask,
  output logic                     req_ready,
  output logic                     res_valid,
  output logic [Q_SIZE-1:0]        res_fx,
  input  logic                     res_ready,
  output logic [Q_SIZE-1:0]        act_x,
  output logic [ACT_MASK_SIZE-1:0] act_mask,
  input  logic [Q_SIZE-1:0]        act_fx,
  output logic                     act_we,
  output logic [ACT_LUT_DEPTH-1:0] act_waddr,
  output logic [ACT_LUT_SIZE-1:0]  act_wdata,
  output logic [31:0]              perf_results,
  output logic [31:0]              perf_stalls
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(ACT_LATENCY + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [ACT_MASK_SIZE-1:0] load_mask_q, load_mask_d;
  logic [ACT_LUT_DEPTH-1:0] waddr_q, waddr_d;
  logic                     load_done_q, load_done_d;
  logic                     busy_q, busy_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic [Q_SIZE-1:0]        act_x_q, act_x_d;
  logic [ACT_MASK_SIZE-1:0] act_mask_q, act_mask_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [Q_SIZE-1:0]        fifo_mem [RES_DEPTH];

  logic op_done, credit_ok, req_accept, load_acc, last_word, push, pop;

  // The op finishing this cycle frees the datapath, so a new x can be issued on the capture edge.
  assign op_done    = busy_q && (lat_q == LAT_W'(ACT_LATENCY));
  assign credit_ok  = ({1'b0, count_q} + {{CNT_W{1'b0}}, busy_q}) < (CNT_W + 1)'(RES_DEPTH);
  assign req_ready  = !rst && (state_q == ST_IDLE) && !load_start && (!busy_q || op_done) && credit_ok;
  assign req_accept = req_valid && req_ready;
  assign load_acc   = (state_q == ST_LOAD) && load_valid;
  assign last_word  = load_acc && (waddr_q == {ACT_LUT_DEPTH{1'b1}});
  assign push       = op_done;
  assign pop        = res_valid && res_ready;

  always_comb begin
    state_d     = state_q;
    load_mask_d = load_mask_q;
    waddr_d     = waddr_q;
    load_done_d = 1'b0;
    busy_d      = busy_q;
    lat_d       = lat_q;
    act_x_d     = act_x_q;
    act_mask_d  = act_mask_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d     = ST_DRAIN;
          load_mask_d = load_mask;
        end
      end
      ST_DRAIN: begin
        if (!busy_q) begin
          state_d    = ST_LOAD;
          act_mask_d = load_mask_q;
        end
      end
      ST_LOAD: begin
        if (load_acc) begin
          waddr_d = waddr_q + ACT_LUT_DEPTH'(1);
          if (last_word) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (req_accept) begin
      busy_d     = 1'b1;
      lat_d      = '0;
      act_x_d    = req_x;
      act_mask_d = req_mask;
    end else if (op_done) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      lat_d = lat_q + LAT_W'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      load_mask_q <= '0;
      waddr_q     <= '0;
      load_done_q <= 1'b0;
      busy_q      <= 1'b0;
      lat_q       <= '0;
      act_x_q     <= '0;
      act_mask_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      load_mask_q <= load_mask_d;
      waddr_q     <= waddr_d;
      load_done_q <= load_done_d;
      busy_q      <= busy_d;
      lat_q       <= lat_d;
      act_x_q     <= act_x_d;
      act_mask_q  <= act_mask_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wr_ptr_q] <= act_fx;
  end

  assign res_valid  = (count_q != '0);
  assign res_fx     = fifo_mem[rd_ptr_q];
  assign load_ready = (state_q == ST_LOAD);
  assign load_done  = load_done_q;
  assign act_x      = act_x_q;
  assign act_mask   = act_mask_q;
  assign act_we     = load_acc;
  assign act_waddr  = waddr_q;
  assign act_wdata  = load_acc ? load_data : '0;

`ifdef ACT_CTRL_PERF_EN
  logic [31:0] perf_results_q, perf_results_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    perf_results_d = perf_results_q;
    perf_stalls_d  = perf_stalls_q;
    if (push && (perf_results_q != 32'hFFFF_FFFF)) perf_results_d = perf_results_q + 32'd1;
    if (req_valid && !req_ready && (perf_stalls_q != 32'hFFFF_FFFF)) perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_results_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_results_q <= perf_results_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_results = perf_results_q;
  assign perf_stalls  = perf_stalls_q;
`else
  assign perf_results = 32'd0;
  assign perf_stalls  = 32'd0;
`endif

endmodule
